tone_note_player: RTL
=====================

TONE_NOTE_PLAYER -- requirements
Module: tone_note_player

Interface
REQ-001 Parameter CNT_W, default 22, width of the half-period count.
REQ-002 Parameter DUR_W, default 16, width of the note-duration field, in ticks.
REQ-003 Parameter TICK_DIV, default 50000, clk cycles per duration tick; legal values are 1 and up.
REQ-004 Parameter GAP_TICKS, default 10, silent ticks inserted after each note; 0 is legal.
REQ-005 Block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 note_valid  input  1  note request present.
REQ-009 note_ready  output  1  block can accept a note.
REQ-010 note_period  input  CNT_W  half-period minus 1, in clk cycles; 0 = rest (silence).
REQ-011 note_dur  input  DUR_W  note length in ticks.
REQ-012 sound  output  1  square-wave tone output, registered.
REQ-013 busy  output  1  high in PLAY or GAP.
REQ-014 done  output  1  one-cycle pulse when a note, including its gap, completes.

Function
REQ-015 FSM SHALL have states IDLE, PLAY and GAP; note_ready = (state == IDLE); busy = (state != IDLE).
REQ-016 A note SHALL be accepted on an edge where note_valid & note_ready; note_period and note_dur SHALL be latched only on that edge.
REQ-017 note_valid while note_ready is low SHALL be ignored; nothing is queued.
REQ-018 On acceptance with note_dur == 0, the FSM SHALL stay in IDLE and done SHALL pulse on the following cycle.
REQ-019 On acceptance with note_dur != 0, the FSM SHALL enter PLAY, and the phase counter, tick prescaler and sound SHALL be cleared to 0.
REQ-020 In PLAY with period P != 0, on the edge where phase == P: sound SHALL toggle and phase SHALL return to 0; otherwise phase SHALL increment. Each half-period is therefore P+1 cycles.
REQ-021 In PLAY with P == 0, sound SHALL stay 0 for the whole note.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; a tick is the wrap edge.
REQ-023 The duration counter SHALL decrement once per tick. PLAY SHALL last exactly note_dur*TICK_DIV cycles.
REQ-024 On the final tick of PLAY, sound SHALL be forced to 0, phase SHALL be cleared, and the FSM SHALL go to GAP, or go directly to IDLE when GAP_TICKS == 0.
REQ-025 GAP SHALL last exactly GAP_TICKS*TICK_DIV cycles with sound at 0, then go to IDLE.
REQ-026 done SHALL be high for exactly the first cycle after each return to IDLE caused by note completion. Per REQ-018, this includes the cycle after a zero-duration acceptance.
REQ-027 A new note accepted in the same cycle that done is high SHALL be legal and SHALL start PLAY normally.
REQ-028 Counter wrap-around SHALL NOT occur: phase is bounded by P and duration by note_dur, with no overflow at P = 2^CNT_W-1.

Reset
REQ-029 On rst_n low, regardless of clk: state = IDLE, sound = 0, done = 0, busy = 0, note_ready = 1, and all counters and latched fields = 0.
REQ-030 Reset asserted mid-note SHALL abort the note without a done pulse. After deassertion, the first accepted note SHALL behave as from power-up.

Verification (TICK_DIV=4, GAP_TICKS=1 unless stated)
REQ-031 Accept period=2, dur=3. Required response:
- sound toggles every 3 cycles for 12 cycles;
- sound = 0 for the 4 GAP cycles;
- done pulses once at cycle 17 after acceptance;
- busy is high for 16 cycles.
REQ-032 Accept period=0, dur=2 -> sound stays 0 for 8+4 cycles, then done pulses.
REQ-033 Accept dur=0 -> FSM stays IDLE, done pulses on the next cycle, sound never leaves 0.
REQ-034 Hold note_valid high with a second note during PLAY. Required response:
- the second note is not accepted until note_ready rises;
- it is then accepted on the done cycle;
- sound starts from 0.
REQ-035 Pull rst_n low 5 cycles into PLAY. Required response:
- sound, busy and done go to 0 immediately, without a clock edge;
- no done pulse follows;
- the next note plays correctly.
REQ-036 With GAP_TICKS=0, accept period=0, dur=1 -> busy high for 4 cycles, then done pulses with no GAP state visited.

Source files
------------

// File: rtl/tone_note_player.sv
// Square-wave note player: accepts one note (half-period, duration in ticks), plays it,
// then holds a silent gap before signalling completion and accepting the next note.
module tone_note_player #(
    parameter int CNT_W     = 22,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [CNT_W-1:0] note_period,
    input  logic [DUR_W-1:0] note_dur,
    output logic             sound,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   period_r, period_s;
    logic [CNT_W-1:0]   phase_r, phase_s;
    logic [DUR_W-1:0]   dur_r, dur_s;
    logic [PRE_W-1:0]   presc_r, presc_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               sound_r, sound_s;
    logic               done_r, done_s;
    logic               ready_r, busy_r;
    logic               tick_s;

    assign tick_s     = (presc_r == PRE_LAST);
    assign note_ready = ready_r;
    assign busy       = busy_r;
    assign sound      = sound_r;
    assign done       = done_r;

    // Next-state, counter and output decode
    always_comb begin
        state_s  = state_r;
        period_s = period_r;
        phase_s  = phase_r;
        dur_s    = dur_r;
        presc_s  = presc_r;
        gap_s    = gap_r;
        sound_s  = sound_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (note_valid) begin
                    period_s = note_period;
                    dur_s    = note_dur;
                    phase_s  = {CNT_W{1'b0}};
                    presc_s  = {PRE_W{1'b0}};
                    sound_s  = 1'b0;
                    if (note_dur == {DUR_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (tick_s) begin
                    presc_s = {PRE_W{1'b0}};
                end else begin
                    presc_s = presc_r + PRE_W'(1);
                end
                if (tick_s && (dur_r == DUR_W'(1))) begin
                    // Last tick of the note: silence and move on to the gap (if any)
                    sound_s = 1'b0;
                    phase_s = {CNT_W{1'b0}};
                    dur_s   = {DUR_W{1'b0}};
                    if (GAP_TICKS == 0) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_GAP;
                        gap_s   = GAP_LOAD;
                    end
                end else begin
                    if (tick_s) begin
                        dur_s = dur_r - DUR_W'(1);
                    end else begin
                        dur_s = dur_r;
                    end
                    if (period_r == {CNT_W{1'b0}}) begin
                        sound_s = 1'b0;
                    end else if (phase_r == period_r) begin
                        sound_s = ~sound_r;
                        phase_s = {CNT_W{1'b0}};
                    end else begin
                        phase_s = phase_r + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                sound_s = 1'b0;
                if (tick_s) begin
                    presc_s = {PRE_W{1'b0}};
                    if (gap_r == GAP_W'(1)) begin
                        state_s = ST_IDLE;
                        gap_s   = {GAP_W{1'b0}};
                        done_s  = 1'b1;
                    end else begin
                        gap_s = gap_r - GAP_W'(1);
                    end
                end else begin
                    presc_s = presc_r + PRE_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                sound_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            period_r <= {CNT_W{1'b0}};
            phase_r  <= {CNT_W{1'b0}};
            dur_r    <= {DUR_W{1'b0}};
            presc_r  <= {PRE_W{1'b0}};
            gap_r    <= {GAP_W{1'b0}};
            sound_r  <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            period_r <= period_s;
            phase_r  <= phase_s;
            dur_r    <= dur_s;
            presc_r  <= presc_s;
            gap_r    <= gap_s;
            sound_r  <= sound_s;
            done_r   <= done_s;
            ready_r  <= (state_s == ST_IDLE);
            busy_r   <= (state_s != ST_IDLE);
        end
    end

endmodule
